pic_priority_resolver_n: RTL and testbench
==========================================

// Module: pic_priority_resolver_n
// PURPOSE
// Parametrised, clocked successor to the 8259A ISR/priority-resolver stage. Takes the
// IRR and IMR vectors, resolves the highest-priority unmasked request against the
// in-service set, and runs the two-pulse INTA acknowledge sequence. Supports fixed and
// rotating priority, normal/auto EOI, specific and non-specific EOI, spurious handling.
// Sits between the IRR/IMR block and the cascade/data-bus vector logic.
// PARAMETERS
// NUM_IR  8                  number of interrupt request lines (2..32)
// ID_W    $clog2(NUM_IR)     width of IR index fields (derived, do not override)
// PORTS
// clk           in   1       system clock, all state updates on rising edge
// rst           in   1       asynchronous active-high reset
// irr           in   NUM_IR  pending requests from IRR block
// imr           in   NUM_IR  mask, 1 = masked
// inta          in   1       acknowledge, active-high, synchronous level; two pulses/cycle
// aeoi          in   1       1 = auto EOI at end of second INTA pulse
// auto_rot      in   1       1 = serviced IR becomes lowest priority when its ISR bit clears
// eoi           in   1       one-cycle EOI command strobe
// eoi_specific  in   1       with eoi: 1 = clear eoi_level, 0 = clear highest in-service
// eoi_level     in   ID_W    target IR of a specific EOI
// set_prio      in   1       one-cycle strobe: lowest-priority pointer := prio_base
// prio_base     in   ID_W    new lowest-priority IR
// int_out       out  1       interrupt request to CPU (registered)
// isr           out  NUM_IR  in-service register
// irr_clear     out  1       one-cycle pulse: clear irr bit irr_clear_id
// irr_clear_id  out  ID_W    index to clear
// vector_valid  out  1       one-cycle pulse on second INTA rise; vector_id is valid
// vector_id     out  ID_W    IR index being acknowledged
// spurious      out  1       high from first INTA rise to end of sequence if none pending
// BEHAVIOUR
// - Reset: isr=0, lowest_ptr=NUM_IR-1 (IR0 highest), FSM=IDLE, all outputs 0.
// - Priority rank of IR i = (i - lowest_ptr - 1) mod NUM_IR; rank 0 highest.
// - cand = highest-rank bit of irr & ~imr; svc = highest-rank bit of isr.
// - int_out (next cycle) = cand exists AND (isr==0 OR rank(cand) < rank(svc)) AND FSM==IDLE.
// - inta rising edge detected against registered copy inta_q; edges only, levels ignored.
// - FSM IDLE: on inta rise -> latch id_q; if cand exists: id_q=cand, isr[cand]<=1,
//   irr_clear=1 for one cycle with irr_clear_id=cand; else id_q=NUM_IR-1, spurious<=1,
//   isr unchanged. -> WAIT2. int_out forced 0 from next cycle.
// - WAIT2: on next inta rise -> vector_valid=1, vector_id=id_q for one cycle; if aeoi
//   and !spurious: isr[id_q]<=0 and, if auto_rot, lowest_ptr<=id_q. spurious<=0. -> IDLE.
// - Latency: irr_clear and isr update one clock after first rising edge; vector one
//   clock after second rising edge.
// - EOI (any state): non-specific clears svc bit (no-op if isr==0); specific clears
//   isr[eoi_level] (no-op if already 0). If auto_rot and a bit was cleared, lowest_ptr
//   <= cleared index. eoi_level >= NUM_IR ignored.
// - Simultaneous events, same cycle: EOI acts on pre-update isr; a set on the same bit
//   wins over the EOI clear. lowest_ptr priority: set_prio > EOI rotation > AEOI
//   rotation. prio_base >= NUM_IR ignored.
// - imr/irr changes during WAIT2 do not alter id_q. Reset mid-sequence aborts to IDLE.
// TESTING
// - Fixed prio: irr=0x24, imr=0 -> int_out=1; two INTA pulses -> irr_clear_id=2, isr=0x04,
//   vector_id=2; then irr=0x01 -> int_out=1 (IR0 preempts); irr=0x20 only -> int_out=0.
// - Spurious: first INTA rise with irr=0 -> spurious=1, isr unchanged, vector_id=7.
// - AEOI+auto_rot: ack IR3 with aeoi=1 -> isr=0 after second pulse, lowest_ptr=3;
//   irr=0x11 -> next ack selects IR4.
// - EOI: isr=0x0A, non-specific eoi -> isr=0x08; specific eoi_level=3 -> isr=0x00.
// - set_prio=1, prio_base=5 with irr=0x41 -> IR6 acked first; NUM_IR=16 run on IR15.
// - rst asserted in WAIT2 -> isr=0, int_out=0, FSM IDLE; next INTA starts fresh sequence.

Source files
------------

// File: rtl/pic_priority_resolver_n.sv
// Clocked 8259A-style priority resolver: picks the highest-rank unmasked request against
// the in-service set, runs the two-pulse INTA acknowledge, and handles EOI/AEOI/rotation.
module pic_priority_resolver_n #(
    parameter int NUM_IR = 8,
    parameter int ID_W   = $clog2(NUM_IR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IR-1:0] irr,
    input  logic [NUM_IR-1:0] imr,
    input  logic              inta,
    input  logic              aeoi,
    input  logic              auto_rot,
    input  logic              eoi,
    input  logic              eoi_specific,
    input  logic [ID_W-1:0]   eoi_level,
    input  logic              set_prio,
    input  logic [ID_W-1:0]   prio_base,
    output logic              int_out,
    output logic [NUM_IR-1:0] isr,
    output logic              irr_clear,
    output logic [ID_W-1:0]   irr_clear_id,
    output logic              vector_valid,
    output logic [ID_W-1:0]   vector_id,
    output logic              spurious
);

    typedef enum logic {IDLE, WAIT2} state_t;

    typedef struct packed {
        logic            found;
        logic [ID_W-1:0] id;
        logic [ID_W-1:0] rank;
    } pick_t;

    // Scan from the IR just above the lowest-priority pointer; the first set bit wins.
    function automatic pick_t pick(input logic [NUM_IR-1:0] vec, input logic [ID_W-1:0] ptr);
        pick_t           r;
        logic [ID_W-1:0] idx;
        r = '0;
        for (int k = 0; k < NUM_IR; k++) begin
            idx = ID_W'((int'(ptr) + 1 + k) % NUM_IR);
            if (!r.found && vec[idx]) begin
                r.found = 1'b1;
                r.id    = idx;
                r.rank  = ID_W'(k);
            end
        end
        return r;
    endfunction

    state_t            state_q, state_d;
    logic              inta_q;
    logic [NUM_IR-1:0] isr_q, isr_d;
    logic [ID_W-1:0]   lowest_q, lowest_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              spurious_q, spurious_d;
    logic              int_out_q, int_out_d;
    logic              irr_clear_q, irr_clear_d;
    logic [ID_W-1:0]   irr_clear_id_q, irr_clear_id_d;
    logic              vector_valid_q, vector_valid_d;
    logic [ID_W-1:0]   vector_id_q, vector_id_d;

    pick_t             cand, svc;
    logic              inta_rise;
    logic              eoi_hit;
    logic [ID_W-1:0]   eoi_idx;

    assign cand      = pick(irr & ~imr, lowest_q);
    assign svc       = pick(isr_q, lowest_q);
    assign inta_rise = inta & ~inta_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        isr_d          = isr_q;
        lowest_d       = lowest_q;
        id_d           = id_q;
        spurious_d     = spurious_q;
        irr_clear_d    = 1'b0;
        irr_clear_id_d = irr_clear_id_q;
        vector_valid_d = 1'b0;
        vector_id_d    = vector_id_q;
        eoi_hit        = 1'b0;
        eoi_idx        = '0;

        // EOI decisions look at the pre-update isr; any set below overrides the clear.
        if (eoi) begin
            if (!eoi_specific) begin
                eoi_hit = svc.found;
                eoi_idx = svc.id;
            end else if (int'(eoi_level) < NUM_IR && isr_q[eoi_level]) begin
                eoi_hit = 1'b1;
                eoi_idx = eoi_level;
            end
        end
        if (eoi_hit) isr_d[eoi_idx] = 1'b0;

        case (state_q)
            IDLE: begin
                if (inta_rise) begin
                    state_d = WAIT2;
                    if (cand.found) begin
                        id_d            = cand.id;
                        isr_d[cand.id]  = 1'b1;
                        irr_clear_d     = 1'b1;
                        irr_clear_id_d  = cand.id;
                    end else begin
                        id_d       = ID_W'(NUM_IR - 1);
                        spurious_d = 1'b1;
                    end
                end
            end
            WAIT2: begin
                if (inta_rise) begin
                    state_d        = IDLE;
                    vector_valid_d = 1'b1;
                    vector_id_d    = id_q;
                    spurious_d     = 1'b0;
                    if (aeoi && !spurious_q) begin
                        isr_d[id_q] = 1'b0;
                        if (auto_rot) lowest_d = id_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Later assignments win: set_prio over EOI rotation over AEOI rotation.
        if (eoi_hit && auto_rot) lowest_d = eoi_idx;
        if (set_prio && int'(prio_base) < NUM_IR) lowest_d = prio_base;

        int_out_d = cand.found && (!svc.found || cand.rank < svc.rank)
                    && state_q == IDLE && !inta_rise;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            inta_q         <= 1'b0;
            isr_q          <= '0;
            lowest_q       <= ID_W'(NUM_IR - 1);
            id_q           <= '0;
            spurious_q     <= 1'b0;
            int_out_q      <= 1'b0;
            irr_clear_q    <= 1'b0;
            irr_clear_id_q <= '0;
            vector_valid_q <= 1'b0;
            vector_id_q    <= '0;
        end else begin
            state_q        <= state_d;
            inta_q         <= inta;
            isr_q          <= isr_d;
            lowest_q       <= lowest_d;
            id_q           <= id_d;
            spurious_q     <= spurious_d;
            int_out_q      <= int_out_d;
            irr_clear_q    <= irr_clear_d;
            irr_clear_id_q <= irr_clear_id_d;
            vector_valid_q <= vector_valid_d;
            vector_id_q    <= vector_id_d;
        end
    end

    assign int_out      = int_out_q;
    assign isr          = isr_q;
    assign irr_clear    = irr_clear_q;
    assign irr_clear_id = irr_clear_id_q;
    assign vector_valid = vector_valid_q;
    assign vector_id    = vector_id_q;
    assign spurious     = spurious_q;

endmodule

// File: tb/tb_pic_priority_resolver_n.sv
// Directed bench for pic_priority_resolver_n: an 8-line instance for most scenarios and a
// 16-line instance for the wide-vector case.
module tb_pic_priority_resolver_n;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irr, imr;
    logic       inta, aeoi, auto_rot, eoi, eoi_specific, set_prio;
    logic [2:0] eoi_level, prio_base;
    logic       int_out, irr_clear, vector_valid, spurious;
    logic [7:0] isr;
    logic [2:0] irr_clear_id, vector_id;

    logic [15:0] h_irr, h_imr, h_isr;
    logic        h_inta;
    logic        h_int_out, h_irr_clear, h_vector_valid, h_spurious;
    logic [3:0]  h_irr_clear_id, h_vector_id;

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    pic_priority_resolver_n #(.NUM_IR(8)) dut8 (
        .clk(clk), .rst(rst), .irr(irr), .imr(imr), .inta(inta), .aeoi(aeoi),
        .auto_rot(auto_rot), .eoi(eoi), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
        .set_prio(set_prio), .prio_base(prio_base), .int_out(int_out), .isr(isr),
        .irr_clear(irr_clear), .irr_clear_id(irr_clear_id), .vector_valid(vector_valid),
        .vector_id(vector_id), .spurious(spurious)
    );

    pic_priority_resolver_n #(.NUM_IR(16)) dut16 (
        .clk(clk), .rst(rst), .irr(h_irr), .imr(h_imr), .inta(h_inta), .aeoi(1'b0),
        .auto_rot(1'b0), .eoi(1'b0), .eoi_specific(1'b0), .eoi_level(4'd0),
        .set_prio(1'b0), .prio_base(4'd0), .int_out(h_int_out), .isr(h_isr),
        .irr_clear(h_irr_clear), .irr_clear_id(h_irr_clear_id),
        .vector_valid(h_vector_valid), .vector_id(h_vector_id), .spurious(h_spurious)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic eoi_pulse(input logic specific, input logic [2:0] level);
        eoi = 1'b1; eoi_specific = specific; eoi_level = level;
        tick;
        eoi = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
    endtask

    task automatic prio_pulse(input logic [2:0] base);
        set_prio = 1'b1; prio_base = base;
        tick;
        set_prio = 1'b0; prio_base = 3'd0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tests_run++;
        if ({int_out, isr, irr_clear, vector_valid, spurious} !== 12'h000) begin
            fails++;
            $display("FAIL reset_outputs: got int=%b isr=%h clr=%b vv=%b sp=%b, want all 0",
                     int_out, isr, irr_clear, vector_valid, spurious);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_fixed_prio;
        irr = 8'h24;
        tick;
        tests_run++;
        if (int_out !== 1'b1) begin
            fails++; $display("FAIL fixed_int_out: got %b want 1", int_out);
        end
        inta = 1'b1;
        tick;
        tests_run++;
        if (irr_clear !== 1'b1 || irr_clear_id !== 3'd2 || isr !== 8'h04 || int_out !== 1'b0) begin
            fails++;
            $display("FAIL fixed_first_ack: got clr=%b id=%0d isr=%h int=%b want 1 2 04 0",
                     irr_clear, irr_clear_id, isr, int_out);
        end
        irr = 8'h20; inta = 1'b0;
        tick;
        tests_run++;
        if (irr_clear !== 1'b0) begin
            fails++; $display("FAIL fixed_clear_pulse: got %b want 0", irr_clear);
        end
        inta = 1'b1;
        tick;
        tests_run++;
        if (vector_valid !== 1'b1 || vector_id !== 3'd2 || isr !== 8'h04) begin
            fails++;
            $display("FAIL fixed_vector: got vv=%b id=%0d isr=%h want 1 2 04",
                     vector_valid, vector_id, isr);
        end
        inta = 1'b0;
        tick;
        tests_run++;
        if (vector_valid !== 1'b0) begin
            fails++; $display("FAIL fixed_vector_pulse: got %b want 0", vector_valid);
        end
        irr = 8'h21;
        tick;
        tests_run++;
        if (int_out !== 1'b1) begin
            fails++; $display("FAIL fixed_preempt: got %b want 1", int_out);
        end
        irr = 8'h20;
        tick;
        tests_run++;
        if (int_out !== 1'b0) begin
            fails++; $display("FAIL fixed_lower_blocked: got %b want 0", int_out);
        end
        irr = 8'h00;
        eoi_pulse(1'b0, 3'd0);
        tests_run++;
        if (isr !== 8'h00) begin
            fails++; $display("FAIL fixed_eoi_cleanup: got %h want 00", isr);
        end
    endtask

    task automatic test_spurious;
        inta = 1'b1;
        tick;
        tests_run++;
        if (spurious !== 1'b1 || isr !== 8'h00 || irr_clear !== 1'b0) begin
            fails++;
            $display("FAIL spur_first: got sp=%b isr=%h clr=%b want 1 00 0", spurious, isr, irr_clear);
        end
        inta = 1'b0;
        tick;
        inta = 1'b1;
        tick;
        tests_run++;
        if (vector_valid !== 1'b1 || vector_id !== 3'd7 || spurious !== 1'b0) begin
            fails++;
            $display("FAIL spur_vector: got vv=%b id=%0d sp=%b want 1 7 0",
                     vector_valid, vector_id, spurious);
        end
        inta = 1'b0;
        tick;
    endtask

    task automatic test_aeoi_rot;
        aeoi = 1'b1; auto_rot = 1'b1; irr = 8'h08;
        tick;
        inta = 1'b1; tick;
        tests_run++;
        if (irr_clear_id !== 3'd3 || isr !== 8'h08) begin
            fails++; $display("FAIL aeoi_first: got id=%0d isr=%h want 3 08", irr_clear_id, isr);
        end
        irr = 8'h00; inta = 1'b0; tick;
        inta = 1'b1; tick;
        tests_run++;
        if (vector_id !== 3'd3 || isr !== 8'h00) begin
            fails++; $display("FAIL aeoi_clear: got id=%0d isr=%h want 3 00", vector_id, isr);
        end
        inta = 1'b0; irr = 8'h11; tick;
        inta = 1'b1; tick;
        tests_run++;
        if (irr_clear_id !== 3'd4) begin
            fails++; $display("FAIL aeoi_rotated_pick: got %0d want 4", irr_clear_id);
        end
        irr = 8'h01; inta = 1'b0; tick;
        inta = 1'b1; tick;
        tests_run++;
        if (vector_id !== 3'd4 || isr !== 8'h00) begin
            fails++; $display("FAIL aeoi_second: got id=%0d isr=%h want 4 00", vector_id, isr);
        end
        inta = 1'b0; irr = 8'h00; aeoi = 1'b0; auto_rot = 1'b0;
        tick;
        prio_pulse(3'd7);
    endtask

    task automatic test_mask_and_eoi;
        irr = 8'h03; imr = 8'h01;
        tick;
        inta = 1'b1; tick;
        tests_run++;
        if (irr_clear_id !== 3'd1 || isr !== 8'h02) begin
            fails++; $display("FAIL mask_pick: got id=%0d isr=%h want 1 02", irr_clear_id, isr);
        end
        irr = 8'h08; imr = 8'h00; inta = 1'b0; tick;
        inta = 1'b1; tick;
        inta = 1'b0; tick;
        inta = 1'b1; tick;
        tests_run++;
        if (irr_clear_id !== 3'd3 || isr !== 8'h0A) begin
            fails++; $display("FAIL eoi_setup: got id=%0d isr=%h want 3 0a", irr_clear_id, isr);
        end
        irr = 8'h00; inta = 1'b0; tick;
        inta = 1'b1; tick;
        inta = 1'b0; tick;
        eoi_pulse(1'b0, 3'd0);
        tests_run++;
        if (isr !== 8'h08) begin
            fails++; $display("FAIL eoi_nonspecific: got %h want 08", isr);
        end
        eoi_pulse(1'b1, 3'd3);
        tests_run++;
        if (isr !== 8'h00) begin
            fails++; $display("FAIL eoi_specific: got %h want 00", isr);
        end
    endtask

    task automatic test_set_prio;
        prio_pulse(3'd5);
        irr = 8'h41;
        tick;
        inta = 1'b1; tick;
        tests_run++;
        if (irr_clear_id !== 3'd6) begin
            fails++; $display("FAIL setprio_pick: got %0d want 6", irr_clear_id);
        end
        irr = 8'h01; inta = 1'b0; tick;
        inta = 1'b1; tick;
        tests_run++;
        if (vector_id !== 3'd6) begin
            fails++; $display("FAIL setprio_vector: got %0d want 6", vector_id);
        end
        inta = 1'b0; irr = 8'h00; tick;
        eoi_pulse(1'b0, 3'd0);
        prio_pulse(3'd7);
    endtask

    task automatic test_wide;
        h_irr = 16'h8000;
        tick;
        tests_run++;
        if (h_int_out !== 1'b1) begin
            fails++; $display("FAIL wide_int_out: got %b want 1", h_int_out);
        end
        h_inta = 1'b1; tick;
        tests_run++;
        if (h_irr_clear_id !== 4'd15 || h_isr !== 16'h8000) begin
            fails++;
            $display("FAIL wide_first: got id=%0d isr=%h want 15 8000", h_irr_clear_id, h_isr);
        end
        h_irr = 16'h0000; h_inta = 1'b0; tick;
        h_inta = 1'b1; tick;
        tests_run++;
        if (h_vector_valid !== 1'b1 || h_vector_id !== 4'd15) begin
            fails++;
            $display("FAIL wide_vector: got vv=%b id=%0d want 1 15", h_vector_valid, h_vector_id);
        end
        h_inta = 1'b0; tick;
    endtask

    task automatic test_reset_mid;
        irr = 8'h04;
        tick;
        inta = 1'b1; tick;
        inta = 1'b0; tick;
        rst = 1'b1;
        #1;
        tests_run++;
        if (isr !== 8'h00 || int_out !== 1'b0) begin
            fails++; $display("FAIL rst_mid: got isr=%h int=%b want 00 0", isr, int_out);
        end
        tick;
        rst = 1'b0;
        tick;
        tests_run++;
        if (int_out !== 1'b1) begin
            fails++; $display("FAIL rst_mid_reint: got %b want 1", int_out);
        end
        inta = 1'b1; tick;
        tests_run++;
        if (irr_clear !== 1'b1 || vector_valid !== 1'b0 || isr !== 8'h04) begin
            fails++;
            $display("FAIL rst_mid_fresh: got clr=%b vv=%b isr=%h want 1 0 04",
                     irr_clear, vector_valid, isr);
        end
        inta = 1'b0; tick;
        inta = 1'b1; tick;
        tests_run++;
        if (vector_valid !== 1'b1 || vector_id !== 3'd2) begin
            fails++;
            $display("FAIL rst_mid_vector: got vv=%b id=%0d want 1 2", vector_valid, vector_id);
        end
        inta = 1'b0; tick;
    endtask

    task automatic test_back_to_back;
        // IR2 still in service; acknowledge it again while a specific EOI targets it.
        inta = 1'b1; eoi = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd2;
        tick;
        eoi = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
        tests_run++;
        if (isr !== 8'h04 || irr_clear_id !== 3'd2) begin
            fails++;
            $display("FAIL set_beats_eoi: got isr=%h id=%0d want 04 2", isr, irr_clear_id);
        end
        irr = 8'h00; inta = 1'b0; tick;
        inta = 1'b1; tick;
        inta = 1'b0; tick;
        eoi_pulse(1'b1, 3'd2);
        tests_run++;
        if (isr !== 8'h00) begin
            fails++; $display("FAIL b2b_cleanup: got %h want 00", isr);
        end
    endtask

    initial begin
        rst = 1'b1; irr = '0; imr = '0; inta = 1'b0; aeoi = 1'b0; auto_rot = 1'b0;
        eoi = 1'b0; eoi_specific = 1'b0; eoi_level = '0; set_prio = 1'b0; prio_base = '0;
        h_irr = '0; h_imr = '0; h_inta = 1'b0;
        test_reset;
        test_fixed_prio;
        test_spurious;
        test_aeoi_rot;
        test_mask_and_eoi;
        test_set_prio;
        test_wide;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
